// File: rtl/host_cmd_mstr.sv
// UART host command master: sends a 3-byte command and receives single response bytes.
// Define HOST_RESP_TIMEOUT_EN to build the response timeout counter; otherwise resp_timeout is tied low.
module host_cmd_mstr #(
  parameter int BAUD_DIV    = 868,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] cmd,
  input  logic        send_cmd,
  output logic        cmd_sent,
  output logic        TX,
  input  logic        RX,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  input  logic        clr_resp_rdy,
  output logic        resp_timeout
);

  localparam int BaudW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(BAUD_DIV - 1);
  localparam logic [BaudW-1:0] BaudHalf = BaudW'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {IDLE, TX_HIGH, TX_MID, TX_LOW} txState_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_e;

  txState_e         txState_q, txState_d;
  logic [23:0]      hold_q, hold_d;
  logic [9:0]       txShift_q, txShift_d;
  logic [3:0]       txBit_q, txBit_d;
  logic [BaudW-1:0] txBaud_q, txBaud_d;
  logic             cmdSent_q, cmdSent_d;

  rxState_e         rxState_q, rxState_d;
  logic             rxMeta_q, rxSync_q, rxPrev_q;
  logic [BaudW-1:0] rxBaud_q, rxBaud_d;
  logic [2:0]       rxBit_q, rxBit_d;
  logic [7:0]       rxShift_q, rxShift_d;
  logic [7:0]       resp_q, resp_d;
  logic             respRdy_q, respRdy_d;
  logic             respSet, startOk;

  always_ff @(posedge clk) begin
    if (rst) begin
      txState_q <= IDLE;
      hold_q    <= '0;
      txShift_q <= '1;
      txBit_q   <= '0;
      txBaud_q  <= '0;
      cmdSent_q <= 1'b0;
      rxState_q <= RX_IDLE;
      rxMeta_q  <= 1'b1;
      rxSync_q  <= 1'b1;
      rxPrev_q  <= 1'b1;
      rxBaud_q  <= '0;
      rxBit_q   <= '0;
      rxShift_q <= '0;
      resp_q    <= '0;
      respRdy_q <= 1'b0;
    end else begin
      txState_q <= txState_d;
      hold_q    <= hold_d;
      txShift_q <= txShift_d;
      txBit_q   <= txBit_d;
      txBaud_q  <= txBaud_d;
      cmdSent_q <= cmdSent_d;
      rxState_q <= rxState_d;
      rxMeta_q  <= RX;
      rxSync_q  <= rxMeta_q;
      rxPrev_q  <= rxSync_q;
      rxBaud_q  <= rxBaud_d;
      rxBit_q   <= rxBit_d;
      rxShift_q <= rxShift_d;
      resp_q    <= resp_d;
      respRdy_q <= respRdy_d;
    end
  end

  // The next byte's frame is loaded on the same edge the stop bit ends, so bytes go out back-to-back.
  always_comb begin
    txState_d = txState_q;
    hold_d    = hold_q;
    txShift_d = txShift_q;
    txBit_d   = txBit_q;
    txBaud_d  = txBaud_q;
    cmdSent_d = cmdSent_q;
    case (txState_q)
      IDLE: begin
        if (send_cmd) begin
          hold_d    = cmd;
          cmdSent_d = 1'b0;
          txState_d = TX_HIGH;
          txShift_d = {1'b1, cmd[23:16], 1'b0};
          txBit_d   = '0;
          txBaud_d  = '0;
        end
      end
      default: begin
        if (txBaud_q != BaudLast) begin
          txBaud_d = txBaud_q + BaudW'(1);
        end else begin
          txBaud_d = '0;
          if (txBit_q != 4'd9) begin
            txBit_d   = txBit_q + 4'd1;
            txShift_d = {1'b1, txShift_q[9:1]};
          end else begin
            txBit_d = '0;
            case (txState_q)
              TX_HIGH: begin
                txState_d = TX_MID;
                txShift_d = {1'b1, hold_q[15:8], 1'b0};
              end
              TX_MID: begin
                txState_d = TX_LOW;
                txShift_d = {1'b1, hold_q[7:0], 1'b0};
              end
              default: begin
                txState_d = IDLE;
                txShift_d = '1;
                cmdSent_d = 1'b1;
              end
            endcase
          end
        end
      end
    endcase
  end

  // Receiver samples mid-bit; a completed byte setting resp_rdy outranks any clear in the same cycle.
  always_comb begin
    rxState_d = rxState_q;
    rxBaud_d  = rxBaud_q;
    rxBit_d   = rxBit_q;
    rxShift_d = rxShift_q;
    resp_d    = resp_q;
    respRdy_d = respRdy_q;
    respSet   = 1'b0;
    startOk   = 1'b0;
    case (rxState_q)
      RX_IDLE: begin
        if (rxPrev_q && !rxSync_q) begin
          rxState_d = RX_START;
          rxBaud_d  = '0;
        end
      end
      RX_START: begin
        if (rxBaud_q == BaudHalf) begin
          rxBaud_d = '0;
          rxBit_d  = '0;
          if (!rxSync_q) begin
            rxState_d = RX_DATA;
            startOk   = 1'b1;
          end else begin
            rxState_d = RX_IDLE;
          end
        end else begin
          rxBaud_d = rxBaud_q + BaudW'(1);
        end
      end
      RX_DATA: begin
        if (rxBaud_q == BaudLast) begin
          rxBaud_d  = '0;
          rxShift_d = {rxSync_q, rxShift_q[7:1]};
          rxBit_d   = rxBit_q + 3'd1;
          if (rxBit_q == 3'd7) rxState_d = RX_STOP;
        end else begin
          rxBaud_d = rxBaud_q + BaudW'(1);
        end
      end
      default: begin
        if (rxBaud_q == BaudLast) begin
          rxBaud_d  = '0;
          rxState_d = RX_IDLE;
          if (rxSync_q) begin
            respSet = 1'b1;
            resp_d  = rxShift_q;
          end
        end else begin
          rxBaud_d = rxBaud_q + BaudW'(1);
        end
      end
    endcase
    if (respSet) respRdy_d = 1'b1;
    else if (clr_resp_rdy || startOk) respRdy_d = 1'b0;
  end

  assign TX       = txShift_q[0];
  assign cmd_sent = cmdSent_q;
  assign resp     = resp_q;
  assign resp_rdy = respRdy_q;

`ifdef HOST_RESP_TIMEOUT_EN
  localparam int ToW = $clog2(TIMEOUT_CYC + 1);

  logic [ToW-1:0] toCnt_q, toCnt_d;
  logic           toRun_q, toRun_d;
  logic           timeout_q, timeout_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      toCnt_q   <= '0;
      toRun_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      toCnt_q   <= toCnt_d;
      toRun_q   <= toRun_d;
      timeout_q <= timeout_d;
    end
  end

  // Timer runs from cmd_sent rising until a response lands; the flag is sticky until the next accepted command.
  always_comb begin
    toCnt_d   = toCnt_q;
    toRun_d   = toRun_q;
    timeout_d = timeout_q;
    if (txState_q == IDLE && send_cmd) begin
      toRun_d   = 1'b0;
      toCnt_d   = '0;
      timeout_d = 1'b0;
    end else if (cmdSent_d && !cmdSent_q) begin
      toRun_d = 1'b1;
      toCnt_d = '0;
    end else if (respSet) begin
      toRun_d = 1'b0;
    end else if (toRun_q) begin
      if (toCnt_q == ToW'(TIMEOUT_CYC - 1)) begin
        timeout_d = 1'b1;
        toRun_d   = 1'b0;
      end else begin
        toCnt_d = toCnt_q + ToW'(1);
      end
    end
  end

  assign resp_timeout = timeout_q;
`else
  assign resp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_host_cmd_mstr.sv
// Scoreboard bench for host_cmd_mstr: expected TX bytes and response bytes are queued at stimulus time
// and popped by independent line monitors.
module tb_host_cmd_mstr;

  localparam int BAUD   = 16;
  localparam int TO_CYC = 1000;
`ifdef HOST_RESP_TIMEOUT_EN
  localparam logic TO_EXPECT = 1'b1;
`else
  localparam logic TO_EXPECT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] cmdIn;
  logic        sendCmd;
  logic        cmdSent;
  logic        txLine;
  logic        rxLine;
  logic [7:0]  resp;
  logic        respRdy;
  logic        clrRespRdy;
  logic        respTimeout;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned txFreeCyc = 0;
  int          resetEpoch = 0;
  logic [7:0]  lastResp = 8'h00;
  logic [7:0]  txExpQ[$];
  logic [7:0]  rxExpQ[$];

  host_cmd_mstr #(.BAUD_DIV(BAUD), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk(clk), .rst(rst), .cmd(cmdIn), .send_cmd(sendCmd), .cmd_sent(cmdSent),
    .TX(txLine), .RX(rxLine), .resp(resp), .resp_rdy(respRdy),
    .clr_resp_rdy(clrRespRdy), .resp_timeout(respTimeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  // Issue a command; the model accepts it only if its own notion of the transmitter is idle.
  task automatic applyStimulus(input logic [23:0] c);
    if (cyc >= txFreeCyc) begin
      txExpQ.push_back(c[23:16]);
      txExpQ.push_back(c[15:8]);
      txExpQ.push_back(c[7:0]);
      txFreeCyc = cyc + 30 * BAUD + 2;
    end
    cmdIn = c;
    sendCmd = 1'b1;
    @(posedge clk); #1;
    sendCmd = 1'b0;
    cmdIn = 24'($urandom);
  endtask

  task automatic sendRxByte(input logic [7:0] b, input logic stopBit);
    logic [9:0] frame;
    frame = {stopBit, b, 1'b0};
    if (stopBit) rxExpQ.push_back(b);
    for (int i = 0; i < 10; i++) begin
      rxLine = frame[i];
      repeat (BAUD) @(posedge clk);
      #1;
    end
    rxLine = 1'b1;
    if (stopBit) lastResp = b;
  endtask

  task automatic waitCmdSent(output int n);
    n = 0;
    while (!cmdSent && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmdSent) begin
      checks++;
      errors++;
      $display("[TB] FAIL cmdSentWait actual=no cmd_sent after %0d clocks required=cmd_sent", n);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    resetEpoch++;
    txExpQ.delete();
    rxExpQ.delete();
    txFreeCyc = 0;
    lastResp = 8'h00;
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("rstTx", txLine, 1);
    checkOutput("rstCmdSent", cmdSent, 0);
    checkOutput("rstResp", resp, 0);
    checkOutput("rstRespRdy", respRdy, 0);
    checkOutput("rstTimeout", respTimeout, 0);
    rst = 1'b0;
  endtask

  // TX line monitor: decodes frames at mid-bit and pops the expected byte.
  initial begin : txMonitor
    logic       prevTx;
    logic [9:0] bits;
    logic       aborted;
    int         epoch;
    logic [7:0] expByte;
    prevTx = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (prevTx && !txLine) begin
        epoch = resetEpoch;
        aborted = 1'b0;
        bits = '0;
        for (int i = 0; i < 10 && !aborted; i++) begin
          repeat ((i == 0) ? BAUD / 2 : BAUD) @(posedge clk);
          #1;
          bits[i] = txLine;
          if (epoch != resetEpoch) aborted = 1'b1;
        end
        if (!aborted) begin
          checkOutput("txStartBit", bits[0], 0);
          checkOutput("txStopBit", bits[9], 1);
          if (txExpQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL txUnexpectedByte actual=%0h required=no byte", bits[8:1]);
          end else begin
            expByte = txExpQ.pop_front();
            checkOutput("txByte", bits[8:1], expByte);
          end
        end
      end
      prevTx = txLine;
    end
  end

  // Response monitor: every rising resp_rdy must match the next queued good byte.
  initial begin : rxMonitor
    logic       prevRdy;
    logic [7:0] expByte;
    prevRdy = 1'b0;
    forever begin
      @(negedge clk);
      if (respRdy && !prevRdy) begin
        if (rxExpQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL respUnexpected actual=%0h required=no resp_rdy", resp);
        end else begin
          expByte = rxExpQ.pop_front();
          checkOutput("respByte", resp, expByte);
        end
      end
      prevRdy = respRdy;
    end
  end

  initial begin : mainSeq
    int n;
    rst = 1'b1;
    rxLine = 1'b1;
    sendCmd = 1'b0;
    clrRespRdy = 1'b0;
    cmdIn = '0;
    idle(3);
    doReset();
    idle(5);

    applyStimulus(24'h082ABB);
    waitCmdSent(n);
    checks++;
    if (n < 474 || n > 486) begin
      errors++;
      $display("[TB] FAIL cmdSentLatency actual=%0d required=480+/-6", n);
    end
    idle(20);

    sendRxByte(8'hA5, 1'b1);
    idle(4);
    checkOutput("respA5", resp, lastResp);
    checkOutput("respRdySet", respRdy, 1);
    clrRespRdy = 1'b1;
    @(posedge clk); #1;
    clrRespRdy = 1'b0;
    checkOutput("respRdyClr", respRdy, 0);

    applyStimulus(24'h123456);
    idle(100);
    applyStimulus(24'hFFFFFF);
    idle(150);
    applyStimulus(24'hFFFFFF);
    waitCmdSent(n);
    idle(250);
    checkOutput("txIdleAfterCmd", txLine, 1);

    rxLine = 1'b0;
    idle(4);
    rxLine = 1'b1;
    idle(40);
    checkOutput("glitchNoRdy", respRdy, 0);
    sendRxByte(8'h55, 1'b0);
    idle(20);
    checkOutput("badStopNoRdy", respRdy, 0);
    checkOutput("badStopRespKept", resp, lastResp);
    sendRxByte(8'h3C, 1'b1);
    idle(4);
    checkOutput("resp3C", resp, lastResp);

    applyStimulus(24'hC3A17E);
    idle(BAUD * 10 + 50);
    doReset();
    idle(40);
    applyStimulus(24'h5A0FF0);
    waitCmdSent(n);
    idle(20);

    applyStimulus(24'h9E3701);
    waitCmdSent(n);
    idle(TO_CYC - 1);
    checkOutput("timeoutBefore", respTimeout, 0);
    idle(1);
    checkOutput("timeoutAt", respTimeout, TO_EXPECT);
    idle(10);
    applyStimulus(24'h010203);
    checkOutput("timeoutCleared", respTimeout, 0);
    waitCmdSent(n);
    idle(20);

    for (int k = 0; k < 6; k++) begin
      fork
        begin
          applyStimulus(24'($urandom));
          waitCmdSent(n);
        end
        begin
          idle($urandom_range(0, 100));
          for (int b = 0; b < 3; b++) begin
            sendRxByte(8'($urandom), $urandom_range(0, 3) != 0);
            idle($urandom_range(2, 20));
          end
        end
      join
      idle(10);
      checkOutput("randRespLast", resp, lastResp);
    end

    idle(200);
    checkOutput("txQueueEmpty", txExpQ.size(), 0);
    checkOutput("rxQueueEmpty", rxExpQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
